// File: rtl/pixel_loader.sv
// Byte-stream to 32-bit word packer feeding the RAM_pixels write port.
// Four accepted bytes form one word, written to consecutive addresses until an image is stored.

module pixel_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld,
    input  logic [7:0] din,
    output logic [7:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (ld) q <= din;
    end
endmodule

module pixel_loader #(
    parameter int          ADDR_W    = 18,
    parameter int          IMG_WORDS = 16384,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [31:0]       data,
    output logic              busy,
    output logic              done
);
    localparam int NUM_LANES = 4;
    localparam int CW        = $clog2(IMG_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                    state;
    logic [1:0]                byte_idx;
    logic [CW-1:0]             word_cnt;
    logic [ADDR_W-1:0]         addr;
    logic                      hs;
    logic [NUM_LANES-1:0][7:0] lanes;

    assign hs = (state == FILL) && in_valid && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            word_cnt <= '0;
            addr     <= ADDR_W'(BASE_ADDR);
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= FILL;
                    byte_idx <= '0;
                    word_cnt <= '0;
                    addr     <= ADDR_W'(BASE_ADDR);
                end
                FILL: begin
                    if (abort) state <= IDLE;
                    else if (in_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    if (abort) state <= IDLE;
                    else begin
                        addr     <= addr + ADDR_W'(1);
                        word_cnt <= word_cnt + CW'(1);
                        state    <= (word_cnt == CW'(IMG_WORDS - 1)) ? DONE : FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i captures the i-th byte of the word; stale lanes after an abort are overwritten before any write.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pixel_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .ld    (hs && (byte_idx == 2'(i))),
            .din   (in_data),
            .q     (lanes[i])
        );
    end

    assign data      = lanes;
    assign wraddress = addr;
    assign in_ready  = (state == FILL);
    assign wren      = (state == WRITE);
    assign busy      = (state == FILL) || (state == WRITE);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_pixel_loader.sv
// Randomized scoreboard bench for pixel_loader with a small-image, wrapping-address configuration.

module tb_pixel_loader;
    localparam int          ADDR_W = 18;
    localparam int          IMG    = 4;
    localparam int unsigned BASE   = 18'h3FFFE;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 0, reset = 1, start = 0, abort = 0, in_valid = 0;
    logic [7:0]        in_data = 0;
    logic              in_ready, wren, busy, done;
    logic [ADDR_W-1:0] wraddress;
    logic [31:0]       data;

    int  errors = 0, checks = 0;
    wr_t exp_q[$];

    // Reference model: accepted-byte queue plus image progress.
    bit       m_active, m_done, m_wr;
    logic [7:0] m_bytes[$];
    int       m_words;
    int unsigned m_addr;

    pixel_loader #(.ADDR_W(ADDR_W), .IMG_WORDS(IMG), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wren(wren), .wraddress(wraddress), .data(data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && wren) begin
            if (exp_q.size() == 0) chk("unexpected_wren", 32'd1, 32'd0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wraddress", 32'(wraddress), 32'(e.a));
                chk("data", data, e.d);
            end
        end
    end

    task automatic model_reset();
        m_active = 0; m_done = 0; m_wr = 0; m_words = 0; m_addr = BASE;
        m_bytes.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic st, input logic ab);
        @(negedge clk);
        chk("in_ready", in_ready, m_active && !m_wr);
        chk("wren", wren, m_wr);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        in_valid = v; in_data = b; start = st; abort = ab;
        @(posedge clk);
        if (m_active) begin
            if (ab) begin
                m_active = 0; m_wr = 0; m_bytes.delete();
            end else if (m_wr) begin
                m_wr = 0;
                m_words++;
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                if (m_words == IMG) begin m_active = 0; m_done = 1; end
            end else if (v) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    wr_t e;
                    e.a = ADDR_W'(m_addr);
                    e.d = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    exp_q.push_back(e);
                    m_bytes.delete();
                    m_wr = 1;
                end
            end
        end else if (st) begin
            m_active = 1; m_done = 0; m_words = 0; m_addr = BASE;
            m_bytes.delete();
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wraddress", 32'(wraddress), BASE);
        chk("rst_data", data, 0);
        reset = 0;

        // Basic pack, then the rest of the image as a continuous stream across the address wrap
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h50 + i), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 8'hEE, 0, 0);

        // Restart from DONE, then gapped valid with occasional stray start/abort
        step(0, 0, 1, 0);
        for (int i = 0; i < 250; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 30) == 0),
                 ($urandom_range(0, 60) == 0));

        // Abort together with the 4th-byte handshake
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 0, 0);
        step(1, 8'hA4, 0, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 8'hB1, 0, 0); step(1, 8'hB2, 0, 0); step(1, 8'hB3, 0, 0); step(1, 8'hB4, 0, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);

        // Reset after two bytes of a fresh load
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(1, 8'hC1, 0, 0); step(1, 8'hC2, 0, 0);
        #2 reset = 1;
        #1;
        chk("async_in_ready", in_ready, 0);
        chk("async_wren", wren, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        model_reset();
        @(negedge clk);
        in_valid = 0; start = 0; abort = 0;
        reset = 0;
        step(1, 8'hD0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 8'hD1, 0, 0); step(1, 8'hD2, 0, 0); step(1, 8'hD3, 0, 0); step(1, 8'hD4, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        chk("pending_writes", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_loader.md
# pixel_loader

Upstream feeder for the `RAM_pixels` write port. It accepts an 8-bit pixel byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit word. It then issues one single-cycle write per word at consecutive word addresses, starting from a base address, until a full image has been stored. Its `wren`, `wraddress` and `data` outputs connect directly to the identically named `RAM_pixels` inputs in the top level.

## Interface
- `ADDR_W`, 18: width of `wraddress`.
- `IMG_WORDS`, 16384: number of 32-bit words per image (256x256 8-bit pixels).
- `BASE_ADDR`, 0: word address of the first write.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that arms a new image load.
- `abort`  in  1  single-cycle pulse that cancels the load in progress.
- `in_data`  in  8  pixel byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts a byte this cycle.
- `wren`  out  1  RAM write enable.
- `wraddress`  out  ADDR_W  RAM word write address.
- `data`  out  32  RAM write data.
- `busy`  out  1  high in FILL or WRITE.
- `done`  out  1  high in DONE.

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `in_ready`=0.
  - `start` → FILL; clear `byte_idx` to 0, `word_cnt` to 0, and load `addr` with `BASE_ADDR`.
- **FILL**
  - `in_ready`=1.
  - A handshake occurs when `in_valid` and `in_ready` are both high.
  - On each handshake: store `in_data` in lane `byte_idx`, then increment `byte_idx` (2 bits).
  - Lane map: 1st byte → `data[7:0]`, 2nd → `[15:8]`, 3rd → `[23:16]`, 4th → `[31:24]`.
  - The handshake that accepts the 4th byte moves the FSM to WRITE.
- **WRITE** (exactly 1 cycle)
  - `in_ready`=0 and `wren`=1, with `wraddress`=`addr` and `data` = the packed word.
  - On exit: `addr` ← `addr`+1, wrapping modulo 2^ADDR_W; `word_cnt` ← `word_cnt`+1.
  - If the new `word_cnt` equals `IMG_WORDS` → DONE, otherwise → FILL.
- **DONE**
  - `done`=1 and `in_ready`=0.
  - `done` holds until a `start`, which re-arms exactly as in IDLE.
- `start` is ignored in FILL and WRITE.
- `abort` in FILL or WRITE → IDLE:
  - Any partial word is discarded.
  - No `wren` is issued in the cycle after the abort.
  - `addr` and `word_cnt` are not preserved.
- `abort` in IDLE or DONE has no effect.
- `abort` and a 4th-byte handshake in the same cycle: abort wins, and no write occurs.
- `abort` and `start` in the same cycle in IDLE or DONE: `start` wins.
- `word_cnt` is $clog2(IMG_WORDS+1) bits wide.
- The address arithmetic is unsigned ADDR_W bits; `BASE_ADDR`+`IMG_WORDS` greater than 2^ADDR_W wraps to 0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs except none; `in_ready` depends only on state.

## Timing
- **Reset values:**
  - State IDLE.
  - `in_ready`=0, `wren`=0, `busy`=0, `done`=0.
  - `wraddress`=`BASE_ADDR`, `data`=0.
- **Latency:** the 4th byte is accepted at edge k; `wren` is high from edge k to edge k+1 and is sampled by the RAM at edge k+1.
- **Throughput:** at most one word per 5 cycles (4 FILL handshakes + 1 WRITE).
- `in_valid` may drop at any time; FILL holds its lanes indefinitely.
- `start` high at edge k → `in_ready`=1 from edge k.
- The last WRITE exits at edge k → `done`=1 from edge k, with `busy` falling at the same edge.
- Asserting `reset` mid-load forces all reset values immediately (asynchronously). The next load requires a fresh `start`.
- `data` and `wraddress` are stable whenever `wren`=1. Their values while `wren`=0 are don't-care.

## Test plan
- **Basic pack and write:**
  - Stimulus: reset, `start`, then bytes 0x11, 0x22, 0x33, 0x44 with `in_valid` held high.
  - Required response: exactly one `wren` pulse with `data`=0x44332211 and `wraddress`=0; the pulse occurs 1 cycle after the 4th byte is accepted.
- **Full image:**
  - Stimulus: `IMG_WORDS`=4, `BASE_ADDR`=0x3FFFE, continuous 16-byte stream.
  - Required response: writes at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; then `done`=1, `in_ready`=0, and further bytes are never accepted.
- **Gapped valid:**
  - Stimulus: `in_valid` toggled randomly during FILL.
  - Required response: word contents match the accepted bytes in order; no `wren` occurs until 4 handshakes have completed.
- **Abort at 4th byte:**
  - Stimulus: `abort` asserted together with the 4th-byte handshake.
  - Required response: no `wren`, state IDLE. A following `start` plus 4 bytes writes to `wraddress`=`BASE_ADDR`.
- **Reset mid-load:**
  - Stimulus: assert `reset` after 2 bytes.
  - Required response: immediate `in_ready`=0, `wren`=0, `busy`=0. After release, `start` restarts the load at `BASE_ADDR` with lane 0.
- **Restart from DONE:**
  - Stimulus: `start` while `done`=1.
  - Required response: `done` drops and `busy` rises on the same edge; the second image overwrites from `BASE_ADDR`.
